// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: active-low segment
// codes (bit 6 = segment g ... bit 0 = segment a), the digit-index type
// and the index -> active-low digit-enable decode.
package seg7_pkg;

   localparam logic [6:0] OFF   = 7'h7F;
   localparam logic [6:0] MINUS = 7'h3F;
   localparam logic [6:0] ZERO  = 7'h40;
   localparam logic [6:0] ONE   = 7'h79;
   localparam logic [6:0] TWO   = 7'h24;
   localparam logic [6:0] THREE = 7'h30;
   localparam logic [6:0] FOUR  = 7'h19;
   localparam logic [6:0] FIVE  = 7'h12;
   localparam logic [6:0] SIX   = 7'h02;
   localparam logic [6:0] SEVEN = 7'h78;
   localparam logic [6:0] EIGHT = 7'h00;
   localparam logic [6:0] NINE  = 7'h10;

   // Slot 0 = units, 1 = tens, 2 = hundreds, 3 = sign.
   typedef logic [1:0] digit_idx_t;

   // Captured per-digit codes, held stable for the whole scan.
   typedef struct packed {
      logic [6:0] sign;
      logic [6:0] d2;
      logic [6:0] d1;
      logic [6:0] d0;
   } seg_codes_t;

   // One-hot-low digit enable for a slot index.
   function automatic logic [3:0] an_decode(input digit_idx_t idx);
      logic [3:0] an_v;
      an_v = 4'b1111;
      case (idx)
         2'd0:    an_v = 4'b1110;
         2'd1:    an_v = 4'b1101;
         2'd2:    an_v = 4'b1011;
         2'd3:    an_v = 4'b0111;
         default: an_v = 4'b1111;
      endcase
      return an_v;
   endfunction

endpackage

// File: rtl/seg7_scan_prescaler.sv
// Slot timebase: prescaler counting 0..SCAN_DIV-1, the 2-bit slot index
// that advances on each prescaler wrap, and the frame-boundary strobe
// (a wrap while the index is on the sign digit).
module seg7_scan_prescaler
   import seg7_pkg::*;
#(
   parameter  int SCAN_DIV = 50000,
   localparam int PW       = $clog2(SCAN_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [PW-1:0] count,
   output digit_idx_t    idx,
   output logic          frame
);

   logic [PW-1:0] count_r;
   digit_idx_t    idx_r;
   logic          tick_s;

   // End of the current digit slot.
   assign tick_s = (count_r == PW'(SCAN_DIV - 1));
   assign frame  = tick_s & (idx_r == 2'd3);
   assign count  = count_r;
   assign idx    = idx_r;

   // Prescaler and slot index; index steps once per completed slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
         idx_r   <= 2'd0;
      end else if (tick_s) begin
         count_r <= '0;
         idx_r   <= idx_r + 2'd1;
      end else begin
         count_r <= count_r + PW'(1);
         idx_r   <= idx_r;
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver. Captures Sign/D2/D1/D0 and
// TooLarge on a frame boundary via a Load/Busy/Ack handshake, scans the
// shadow codes onto a shared active-low bus, and blinks the display while
// the captured TooLarge is set.
// Optional build macro SCAN_DEADTIME_EN: blanks An/Seg for the first
// DEAD_CYCLES cycles of every slot (anti-ghosting dead time).
module seven_seg_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter int DEAD_CYCLES  = 8
) (
   input  logic       Clock,
   input  logic       ResetN,
   input  logic [6:0] Sign,
   input  logic [6:0] D2,
   input  logic [6:0] D1,
   input  logic [6:0] D0,
   input  logic       TooLarge,
   input  logic       Load,
   output logic       Busy,
   output logic       Ack,
   output logic [6:0] Seg,
   output logic [3:0] An
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

`ifdef SCAN_DEADTIME_EN
   localparam logic DEAD_EN = 1'b1;
`else
   localparam logic DEAD_EN = 1'b0;
`endif

   logic [PW-1:0] count_s;
   digit_idx_t    idx_s;
   logic          frame_s;
   logic          capture_s;
   logic          restart_s;
   logic          wrap_s;
   logic          dead_s;
   logic          busy_r;
   logic          ack_r;
   seg_codes_t    shadow_r;
   logic          tl_r;
   logic [FW-1:0] frame_cnt_r;
   logic          blank_r;
   logic [6:0]    code_s;

   seg7_scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_prescaler (
      .clk   (Clock),
      .rst_n (ResetN),
      .count (count_s),
      .idx   (idx_s),
      .frame (frame_s)
   );

   // A Load in the boundary cycle itself is served by that capture.
   assign capture_s = frame_s & (busy_r | Load);
   assign restart_s = capture_s & ~tl_r & TooLarge;
   assign wrap_s    = (frame_cnt_r == FW'(BLINK_FRAMES - 1));
   assign dead_s    = DEAD_EN & (count_s < PW'(DEAD_CYCLES));

   // Handshake: pending-request flag and one-cycle capture acknowledge.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         busy_r <= 1'b0;
         ack_r  <= 1'b0;
      end else begin
         ack_r <= capture_s;
         if (capture_s) begin
            busy_r <= 1'b0;
         end else if (Load) begin
            busy_r <= 1'b1;
         end else begin
            busy_r <= busy_r;
         end
      end
   end

   // Shadow registers: snapshot of the converter outputs at capture.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         shadow_r <= '{sign: OFF, d2: OFF, d1: OFF, d0: OFF};
         tl_r     <= 1'b0;
      end else if (capture_s) begin
         shadow_r <= '{sign: Sign, d2: D2, d1: D1, d0: D0};
         tl_r     <= TooLarge;
      end else begin
         shadow_r <= shadow_r;
         tl_r     <= tl_r;
      end
   end

   // Blink timebase: frame counter and visible/blank phase; a fresh
   // overflow starts on a visible half-period.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         frame_cnt_r <= '0;
         blank_r     <= 1'b0;
      end else if (restart_s) begin
         frame_cnt_r <= '0;
         blank_r     <= 1'b0;
      end else if (frame_s) begin
         if (wrap_s) begin
            frame_cnt_r <= '0;
            blank_r     <= ~blank_r;
         end else begin
            frame_cnt_r <= frame_cnt_r + FW'(1);
            blank_r     <= blank_r;
         end
      end else begin
         frame_cnt_r <= frame_cnt_r;
         blank_r     <= blank_r;
      end
   end

   // Select the shadow code for the active slot.
   always_comb begin
      code_s = OFF;
      case (idx_s)
         2'd0:    code_s = shadow_r.d0;
         2'd1:    code_s = shadow_r.d1;
         2'd2:    code_s = shadow_r.d2;
         2'd3:    code_s = shadow_r.sign;
         default: code_s = OFF;
      endcase
   end

   // Display outputs decoded from registered state only.
   always_comb begin
      An  = 4'b1111;
      Seg = OFF;
      if (dead_s) begin
         An  = 4'b1111;
         Seg = OFF;
      end else begin
         An = an_decode(idx_s);
         if (tl_r && blank_r) begin
            Seg = OFF;
         end else begin
            Seg = code_s;
         end
      end
   end

   assign Busy = busy_r;
   assign Ack  = ack_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver with
// SCAN_DIV=4, BLINK_FRAMES=2, DEAD_CYCLES=1. A free-running cycle counter
// (cleared by reset) gives the expected slot position: prescaler = cyc%4,
// slot = (cyc/4)%4, frame-boundary cycle = cyc%16 == 15.
module tb_seven_seg_scan_driver;

   localparam int SD = 4;
   localparam int BF = 2;
   localparam int DC = 1;

   logic       Clock = 1'b0;
   logic       ResetN = 1'b0;
   logic [6:0] Sign = 7'h00;
   logic [6:0] D2 = 7'h00;
   logic [6:0] D1 = 7'h00;
   logic [6:0] D0 = 7'h00;
   logic       TooLarge = 1'b0;
   logic       Load = 1'b1;
   logic       Busy;
   logic       Ack;
   logic [6:0] Seg;
   logic [3:0] An;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   seven_seg_scan_driver #(
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF),
      .DEAD_CYCLES  (DC)
   ) dut (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .Sign     (Sign),
      .D2       (D2),
      .D1       (D1),
      .D0       (D0),
      .TooLarge (TooLarge),
      .Load     (Load),
      .Busy     (Busy),
      .Ack      (Ack),
      .Seg      (Seg),
      .An       (An)
   );

   always #5 Clock = ~Clock;

   // Bench timebase: cycles since reset release.
   always @(posedge Clock or negedge ResetN) begin
      if (!ResetN) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   function automatic logic dead(input int c);
`ifdef SCAN_DEADTIME_EN
      return (c % SD) < DC;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] exp_an(input int c);
      logic [3:0] a;
      a = 4'b1111;
      if (!dead(c)) begin
         case ((c / SD) % 4)
            0:       a = 4'b1110;
            1:       a = 4'b1101;
            2:       a = 4'b1011;
            default: a = 4'b0111;
         endcase
      end
      return a;
   endfunction

   function automatic logic [6:0] exp_seg(input int c, input logic [6:0] v);
      return dead(c) ? 7'h7F : v;
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (An !== exp_an(0)) begin n_bad++; $display("FAIL reset_an: got %b want %b", An, exp_an(0)); end
      n_cmp++; if (Seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %h want 7f", Seg); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", Ack); end
      step();
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_load: got %b want 0", Busy); end
      @(negedge Clock);
      ResetN = 1'b1;
      Load = 1'b0;
      #1;
      for (int j = 0; j < 16; j++) begin
         n_cmp++; if (An !== exp_an(cyc)) begin n_bad++; $display("FAIL post_reset_an cyc=%0d: got %b want %b", cyc, An, exp_an(cyc)); end
         n_cmp++; if (Seg !== 7'h7F) begin n_bad++; $display("FAIL post_reset_seg cyc=%0d: got %h want 7f", cyc, Seg); end
         step();
      end
   endtask

   task automatic test_capture();
      int lat;
      for (int k = 0; k < 20 && (cyc % 16) != 4; k++) step();
      Sign = 7'h3F; D2 = 7'h24; D1 = 7'h30; D0 = 7'h79; TooLarge = 1'b0;
      Load = 1'b1;
      step();
      Load = 1'b0;
      lat = 1;
      while (Ack !== 1'b1 && lat < 20) begin
         n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL capture_busy cyc=%0d: got %b want 1", cyc, Busy); end
         step();
         lat++;
      end
      n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL capture_latency: got %0d want 12", lat); end
      n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL capture_ack: got %b want 1", Ack); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL capture_busy_clear: got %b want 0", Busy); end
   endtask

   task automatic test_scan_order();
      logic [6:0] codes [4];
      logic [6:0] want;
      codes[0] = 7'h79; codes[1] = 7'h30; codes[2] = 7'h24; codes[3] = 7'h3F;
      for (int j = 0; j < 16; j++) begin
         want = exp_seg(cyc, codes[(cyc / SD) % 4]);
         n_cmp++; if (An !== exp_an(cyc)) begin n_bad++; $display("FAIL scan_an cyc=%0d: got %b want %b", cyc, An, exp_an(cyc)); end
         n_cmp++; if (Seg !== want) begin n_bad++; $display("FAIL scan_seg cyc=%0d: got %h want %h", cyc, Seg, want); end
         if (j == 1) begin
            n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL ack_one_cycle: got %b want 0", Ack); end
         end
         step();
      end
   endtask

   task automatic test_blink();
      int lat;
      logic [6:0] want;
      Sign = 7'h3F; D2 = 7'h3F; D1 = 7'h3F; D0 = 7'h3F; TooLarge = 1'b1;
      Load = 1'b1;
      step();
      Load = 1'b0;
      lat = 1;
      while (Ack !== 1'b1 && lat < 40) begin step(); lat++; end
      n_cmp++; if (lat != 16) begin n_bad++; $display("FAIL blink_capture_latency: got %0d want 16", lat); end
      for (int j = 0; j < 128; j++) begin
         want = exp_seg(cyc, ((j / 32) % 2 == 0) ? 7'h3F : 7'h7F);
         n_cmp++; if (Seg !== want) begin n_bad++; $display("FAIL blink_seg j=%0d: got %h want %h", j, Seg, want); end
         n_cmp++; if (An !== exp_an(cyc)) begin n_bad++; $display("FAIL blink_an j=%0d: got %b want %b", j, An, exp_an(cyc)); end
         step();
      end
   endtask

   task automatic test_load_held();
      int acks;
      int k;
      TooLarge = 1'b0;
      Sign = 7'h40; D2 = 7'h40; D1 = 7'h40; D0 = 7'h40;
      acks = 0;
      for (int i = 0; i < 48; i++) begin
         Load = (i < 40);
         step();
         k = (i + 1) % 16;
         if (Ack === 1'b1) acks++;
         n_cmp++; if (Ack !== (k == 0)) begin n_bad++; $display("FAIL held_ack i=%0d: got %b want %b", i, Ack, (k == 0)); end
         n_cmp++; if (Busy !== (k != 0)) begin n_bad++; $display("FAIL held_busy i=%0d: got %b want %b", i, Busy, (k != 0)); end
      end
      Load = 1'b0;
      n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL held_ack_count: got %0d want 3", acks); end
   endtask

   task automatic test_boundary_load();
      for (int k = 0; k < 20 && (cyc % 16) != 15; k++) begin
         step();
         n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL boundary_idle_busy cyc=%0d: got %b want 0", cyc, Busy); end
      end
      Load = 1'b1;
      step();
      Load = 1'b0;
      n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL boundary_ack: got %b want 1", Ack); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL boundary_busy: got %b want 0", Busy); end
      n_cmp++; if (Seg !== exp_seg(cyc, 7'h40)) begin n_bad++; $display("FAIL boundary_seg: got %h want 40", Seg); end
      step();
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL boundary_ack_drop: got %b want 0", Ack); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL boundary_busy_after: got %b want 0", Busy); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 20 && (cyc % 16) != 8; k++) step();
      Load = 1'b1;
      step();
      Load = 1'b0;
      n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", Busy); end
      n_cmp++; if (An !== exp_an(cyc)) begin n_bad++; $display("FAIL mid_an_before: got %b want %b", An, exp_an(cyc)); end
      #2;
      ResetN = 1'b0;
      #1;
      n_cmp++; if (An !== exp_an(0)) begin n_bad++; $display("FAIL mid_reset_an: got %b want %b", An, exp_an(0)); end
      n_cmp++; if (Seg !== 7'h7F) begin n_bad++; $display("FAIL mid_reset_seg: got %h want 7f", Seg); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", Busy); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ack: got %b want 0", Ack); end
      @(negedge Clock);
      ResetN = 1'b1;
      #1;
      for (int j = 0; j < 32; j++) begin
         n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL mid_post_ack cyc=%0d: got %b want 0", cyc, Ack); end
         n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL mid_post_busy cyc=%0d: got %b want 0", cyc, Busy); end
         n_cmp++; if (Seg !== 7'h7F) begin n_bad++; $display("FAIL mid_post_seg cyc=%0d: got %h want 7f", cyc, Seg); end
         n_cmp++; if (An !== exp_an(cyc)) begin n_bad++; $display("FAIL mid_post_an cyc=%0d: got %b want %b", cyc, An, exp_an(cyc)); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_scan_order();
      test_blink();
      test_load_held();
      test_boundary_load();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
